// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - posted-write bridge between processor data port and synchronous data memory
module data_bus_bridge #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [15:0]              DataAddr,
    input  logic [DATA_W-1:0]        DataOut,
    input  logic                     WriteData,
    input  logic                     ReadData,
    output logic [DATA_W-1:0]        DataIn,
    output logic                     DataWaitreq,
    output logic [ADDR_W-1:0]        MemAddr,
    output logic [DATA_W-1:0]        MemWData,
    output logic                     MemWren,
    input  logic [DATA_W-1:0]        MemRData,
    input  logic                     MemBusy,
    output logic [$clog2(DEPTH):0]   BufCount,
    output logic                     BufEmpty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  buf_addr_q [DEPTH];
    logic [DATA_W-1:0]  buf_data_q [DEPTH];

    logic [ADDR_W-1:0]  req_addr;
    logic               full;
    logic               hit;
    logic [DATA_W-1:0]  hit_data;
    logic [PTR_W-1:0]   idx;
    logic               push, pop, rd_issue;

    assign req_addr = DataAddr[ADDR_W-1:0];
    assign full     = (count_q == CNT_W'(DEPTH));

    generate
        if (ADDR_W < 16) begin : g_unused_addr
            logic unused_addr;
            assign unused_addr = ^DataAddr[15:ADDR_W];
        end
    endgenerate

    // Scan oldest to youngest so the last match wins: youngest write forwards.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (buf_addr_q[idx] == req_addr)) begin
                hit      = 1'b1;
                hit_data = buf_data_q[idx];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        pop         = 1'b0;
        rd_issue    = 1'b0;
        DataIn      = '0;
        DataWaitreq = 1'b0;
        MemAddr     = '0;
        MemWData    = '0;
        MemWren     = 1'b0;
        if (!Reset) begin
            DataWaitreq = 1'b1;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (WriteData) begin
                        push        = !full;
                        DataWaitreq = full;
                    end else if (ReadData) begin
                        if (hit) begin
                            DataIn = hit_data;
                        end else begin
                            DataWaitreq = 1'b1;
                            if (!MemBusy) begin
                                rd_issue = 1'b1;
                                MemAddr  = req_addr;
                                state_d  = RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    DataIn  = MemRData;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // A read issue owns the memory port; otherwise drain the oldest entry.
            if (!rd_issue && !MemBusy && (count_q != '0)) begin
                pop      = 1'b1;
                MemWren  = 1'b1;
                MemAddr  = buf_addr_q[head_q];
                MemWData = buf_data_q[head_q];
            end
        end
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            buf_addr_q[tail_q] <= req_addr;
            buf_data_q[tail_q] <= DataOut;
        end
    end

    assign BufCount = Reset ? count_q : '0;
    assign BufEmpty = (BufCount == '0);
endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - self-checking bench for data_bus_bridge
module tb_data_bus_bridge;
    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] DataAddr;
    logic [15:0] DataOut;
    logic        WriteData;
    logic        ReadData;
    logic [15:0] DataIn;
    logic        DataWaitreq;
    logic [11:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemWren;
    logic [15:0] MemRData;
    logic        MemBusy;
    logic [2:0]  BufCount;
    logic        BufEmpty;

    int errors = 0;
    int checks = 0;

    data_bus_bridge #(.DEPTH(4), .ADDR_W(12), .DATA_W(16)) dut (
        .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
        .WriteData(WriteData), .ReadData(ReadData), .DataIn(DataIn),
        .DataWaitreq(DataWaitreq), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemWren(MemWren), .MemRData(MemRData), .MemBusy(MemBusy),
        .BufCount(BufCount), .BufEmpty(BufEmpty)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    bit [15:0]   mem [4096];
    bit          wr_valid [4096];
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;
    wr_t         wlog [$];

    function automatic logic [15:0] init_val(input logic [11:0] a);
        return {a[3:0], a} ^ 16'hC3A5;
    endfunction

    always @(posedge Clock) begin
        if (ld_en) begin
            mem[ld_addr]      <= ld_data;
            wr_valid[ld_addr] <= 1'b1;
        end
        if (MemWren) begin
            mem[MemAddr]      <= MemWData;
            wr_valid[MemAddr] <= 1'b1;
            wlog.push_back({MemAddr, MemWData});
        end
        MemRData <= wr_valid[MemAddr] ? mem[MemAddr] : init_val(MemAddr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        WriteData = 1'b0;
        ReadData  = 1'b0;
        DataAddr  = 16'h0;
        DataOut   = 16'h0;
    endtask

    task automatic drive(input bit w, input bit r, input logic [15:0] a, input logic [15:0] d);
        WriteData = w;
        ReadData  = r;
        DataAddr  = a;
        DataOut   = d;
    endtask

    typedef struct packed {
        bit          wr, rd, busy;
        logic [15:0] addr, data;
        bit          chk_w, ew, ewren;
        logic [11:0] emaddr;
        logic [15:0] ewdata, edin;
        logic [2:0]  ecnt;
    } vec_t;

    function automatic vec_t mk(bit wr, bit rd, bit busy, logic [15:0] addr, logic [15:0] data,
                                bit chk_w, bit ew, bit ewren, logic [11:0] emaddr,
                                logic [15:0] ewdata, logic [15:0] edin, logic [2:0] ecnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.busy = busy; v.addr = addr; v.data = data;
        v.chk_w = chk_w; v.ew = ew; v.ewren = ewren; v.emaddr = emaddr;
        v.ewdata = ewdata; v.edin = edin; v.ecnt = ecnt;
        return v;
    endfunction

    vec_t        tbl [12];
    wr_t         q [$];
    logic [15:0] ref8 [8];

    initial begin
        int          base, stalls;
        bit          done, req_active, cur_w, cur_r, ret_pending, rd_issue, hit, exp_wren, full;
        logic [15:0] cur_addr, cur_data;
        logic [3:0]  up;
        logic [2:0]  lo;
        int          r;

        tbl[0]  = mk(1, 0, 0, 16'h0010, 16'hBEEF, 1, 0, 0, 12'h000, 16'h0000, 16'h0000, 3'd0);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 12'h010, 16'hBEEF, 16'h0000, 3'd1);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 12'h000, 16'h0000, 16'h0000, 3'd0);
        tbl[3]  = mk(1, 0, 1, 16'hF020, 16'h1111, 1, 0, 0, 12'h000, 16'h0000, 16'h0000, 3'd0);
        tbl[4]  = mk(1, 0, 1, 16'h0020, 16'h2222, 1, 0, 0, 12'h000, 16'h0000, 16'h0000, 3'd1);
        tbl[5]  = mk(0, 1, 1, 16'h0020, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 16'h2222, 3'd2);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 12'h020, 16'h1111, 16'h0000, 3'd2);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 12'h020, 16'h2222, 16'h0000, 3'd1);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 12'h000, 16'h0000, 16'h0000, 3'd0);
        tbl[9]  = mk(0, 1, 0, 16'h0030, 16'h0000, 1, 1, 0, 12'h030, 16'h0000, 16'h0000, 3'd0);
        tbl[10] = mk(0, 1, 0, 16'h0030, 16'h0000, 1, 0, 0, 12'h000, 16'h0000, 16'h5A5A, 3'd0);
        tbl[11] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 12'h000, 16'h0000, 16'h0000, 3'd0);

        // reset state, with memory[0x030] preloaded
        Reset = 1'b0; MemBusy = 1'b0; idle_in();
        ld_en = 1'b1; ld_addr = 12'h030; ld_data = 16'h5A5A;
        @(negedge Clock); #1;
        ld_en = 1'b0;
        chk("rst_wait",  32'(DataWaitreq), 32'd1);
        chk("rst_wren",  32'(MemWren),     32'd0);
        chk("rst_maddr", 32'(MemAddr),     32'd0);
        chk("rst_wdata", 32'(MemWData),    32'd0);
        chk("rst_din",   32'(DataIn),      32'd0);
        chk("rst_cnt",   32'(BufCount),    32'd0);
        chk("rst_empty", 32'(BufEmpty),    32'd1);
        @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data);
            MemBusy = tbl[i].busy;
            #1;
            if (tbl[i].chk_w) chk($sformatf("t%0d_wait", i), 32'(DataWaitreq), 32'(tbl[i].ew));
            chk($sformatf("t%0d_wren", i),  32'(MemWren),  32'(tbl[i].ewren));
            chk($sformatf("t%0d_maddr", i), 32'(MemAddr),  32'(tbl[i].emaddr));
            chk($sformatf("t%0d_wdata", i), 32'(MemWData), 32'(tbl[i].ewdata));
            chk($sformatf("t%0d_din", i),   32'(DataIn),   32'(tbl[i].edin));
            chk($sformatf("t%0d_cnt", i),   32'(BufCount), 32'(tbl[i].ecnt));
            chk($sformatf("t%0d_empty", i), 32'(BufEmpty), 32'(tbl[i].ecnt == 3'd0));
            @(negedge Clock);
        end

        // read miss with MemBusy high for three cycles
        drive(0, 1, 16'h0030, 16'h0);
        stalls = 0; done = 0;
        for (int c = 0; c < 20; c++) begin
            MemBusy = (c < 3);
            #1;
            if (!DataWaitreq) begin
                done = 1;
                chk("miss_din", 32'(DataIn), 32'h5A5A);
                break;
            end
            stalls++;
            @(negedge Clock);
        end
        chk("miss_done", 32'(done), 32'd1);
        chk("miss_stalls", 32'(stalls), 32'd4);
        idle_in(); MemBusy = 1'b0;
        @(negedge Clock);

        // full buffer, stalled fifth write, recovery and ordered drain
        base = wlog.size();
        MemBusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 16'h0040 + 16'(i), 16'hA000 + 16'(i));
            #1; chk($sformatf("full_acc%0d", i), 32'(DataWaitreq), 32'd0);
            @(negedge Clock);
        end
        drive(1, 0, 16'h0044, 16'hA004);
        #1; chk("full_stall", 32'(DataWaitreq), 32'd1);
        chk("full_cnt", 32'(BufCount), 32'd4);
        @(negedge Clock);
        MemBusy = 1'b0;
        #1; chk("full_drop_stall", 32'(DataWaitreq), 32'd1);
        @(negedge Clock);
        #1; chk("full_recover", 32'(DataWaitreq), 32'd0);
        @(negedge Clock);
        idle_in();
        for (int c = 0; c < 20 && wlog.size() < base + 5; c++) @(negedge Clock);
        chk("full_drain_n", 32'(wlog.size() - base), 32'd5);
        for (int k = 0; k < 5; k++)
            if (base + k < wlog.size())
                chk($sformatf("full_drain%0d", k), 32'(wlog[base + k]), {4'h0, 12'h040 + 12'(k), 16'hA000 + 16'(k)});

        // read miss takes the memory port over a pending drain
        MemBusy = 1'b1;
        drive(1, 0, 16'h0050, 16'hB000); #1; chk("prio_w0", 32'(DataWaitreq), 32'd0); @(negedge Clock);
        drive(1, 0, 16'h0051, 16'hB001); #1; chk("prio_w1", 32'(DataWaitreq), 32'd0); @(negedge Clock);
        drive(0, 1, 16'h0030, 16'h0); MemBusy = 1'b0;
        #1;
        chk("prio_wait", 32'(DataWaitreq), 32'd1);
        chk("prio_wren", 32'(MemWren), 32'd0);
        chk("prio_maddr", 32'(MemAddr), 32'h030);
        chk("prio_cnt", 32'(BufCount), 32'd2);
        @(negedge Clock); #1;
        chk("prio_ret_wait", 32'(DataWaitreq), 32'd0);
        chk("prio_ret_din", 32'(DataIn), 32'h5A5A);
        chk("prio_ret_wren", 32'(MemWren), 32'd1);
        chk("prio_ret_maddr", 32'(MemAddr), 32'h050);
        chk("prio_ret_wdata", 32'(MemWData), 32'hB000);
        @(negedge Clock); idle_in(); #1;
        chk("prio_d2_wren", 32'(MemWren), 32'd1);
        chk("prio_d2_maddr", 32'(MemAddr), 32'h051);
        @(negedge Clock); @(negedge Clock);

        // randomized traffic against a posted-write memory model
        for (int j = 0; j < 8; j++) ref8[j] = init_val(12'h100 + 12'(j));
        q.delete();
        req_active = 0; ret_pending = 0; cur_w = 0; cur_r = 0; cur_addr = 0; cur_data = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!req_active) begin
                r  = $urandom_range(0, 9);
                up = 4'($urandom_range(0, 15));
                lo = 3'($urandom_range(0, 7));
                cur_addr = {up, 4'h1, 5'b00000, lo};
                cur_data = 16'($urandom);
                cur_w = (r <= 3) || (r == 8);
                cur_r = (r >= 4 && r <= 8);
                req_active = (r != 9);
            end
            drive(cur_w, cur_r, cur_addr, cur_data);
            MemBusy = ($urandom_range(0, 9) < 3);
            #1;
            rd_issue = 0; done = 0;
            chk("rnd_cnt", 32'(BufCount), 32'(q.size()));
            chk("rnd_empty", 32'(BufEmpty), 32'(q.size() == 0));
            full = (q.size() == DEPTH);
            if (ret_pending) begin
                chk("rnd_ret_wait", 32'(DataWaitreq), 32'd0);
                chk("rnd_ret_din", 32'(DataIn), 32'(ref8[cur_addr[2:0]]));
                done = 1;
            end else if (cur_w) begin
                chk("rnd_w_wait", 32'(DataWaitreq), 32'(full));
            end else if (cur_r) begin
                hit = 0;
                foreach (q[k]) if (q[k].a == cur_addr[11:0]) hit = 1;
                if (hit) begin
                    chk("rnd_hit_wait", 32'(DataWaitreq), 32'd0);
                    chk("rnd_hit_din", 32'(DataIn), 32'(ref8[cur_addr[2:0]]));
                    done = 1;
                end else begin
                    chk("rnd_miss_wait", 32'(DataWaitreq), 32'd1);
                    rd_issue = !MemBusy;
                end
            end
            exp_wren = !rd_issue && !MemBusy && (q.size() > 0);
            chk("rnd_wren", 32'(MemWren), 32'(exp_wren));
            if (exp_wren) begin
                chk("rnd_drain", {4'h0, MemAddr, MemWData}, 32'(q[0]));
                void'(q.pop_front());
            end
            if (rd_issue) chk("rnd_rd_addr", 32'(MemAddr), 32'(cur_addr[11:0]));
            if (!ret_pending && cur_w && !full) begin
                q.push_back({cur_addr[11:0], cur_data});
                ref8[cur_addr[2:0]] = cur_data;
                done = 1;
            end
            ret_pending = rd_issue;
            if (done) req_active = 0;
            @(negedge Clock);
        end
        idle_in(); MemBusy = 1'b0;
        repeat (8) @(negedge Clock);

        // reset while entries are buffered discards them
        MemBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'h0060 + 16'(i), 16'hC000 + 16'(i));
            @(negedge Clock);
        end
        idle_in(); Reset = 1'b0; MemBusy = 1'b0;
        #1;
        chk("mrst_wait", 32'(DataWaitreq), 32'd1);
        chk("mrst_wren", 32'(MemWren), 32'd0);
        chk("mrst_cnt", 32'(BufCount), 32'd0);
        chk("mrst_empty", 32'(BufEmpty), 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        base = wlog.size();
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("mrst_post_wren%0d", c), 32'(MemWren), 32'd0);
            chk($sformatf("mrst_post_cnt%0d", c), 32'(BufCount), 32'd0);
            @(negedge Clock);
        end
        chk("mrst_no_writes", 32'(wlog.size() - base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
